foc_sample_sequencer: RTL and testbench

FOC_SAMPLE_SEQUENCER -- requirements
Module: foc_sample_sequencer

---
 rtl/pmsm_pkg.sv | 14 +
 rtl/foc_seq_wdt.sv | 39 +++
 rtl/foc_sample_sequencer.sv | 173 +++++++++++++++++
 tb/tb_foc_sample_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmsm_pkg.sv
// Shared types and constants for the PMSM sampling and control path.
package pmsm_pkg;

    localparam int ADC_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV0 = 3'd1,
        CONV1 = 3'd2,
        FOC   = 3'd3,
        VEL   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/foc_seq_wdt.sv
// ADC acknowledge watchdog for the sample sequencer.
// Compiled only when SEQ_ADC_TIMEOUT_EN is defined.
`ifdef SEQ_ADC_TIMEOUT_EN
module foc_seq_wdt #(
    parameter int TO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TO + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run || clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TO-th consecutive waiting cycle; an ack in that cycle wins.
    assign expired = run && !clr && (cnt_q == CW'(TO - 1));

endmodule
`endif

// File: rtl/foc_sample_sequencer.sv
// Sequences two-phase ADC sampling at PWM center, then the current and velocity loops.
// Optional ADC ack watchdog enabled by SEQ_ADC_TIMEOUT_EN.
module foc_sample_sequencer
    import pmsm_pkg::*;
#(
    parameter int ADC_W   = ADC_W_DEF,
    parameter int VEL_DIV = 10,
    parameter int ADC_TO  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pwm_center,
    output logic                  adc_req,
    output logic                  adc_ch,
    input  logic                  adc_ack,
    input  logic [ADC_W-1:0]      adc_data,
    output logic [1:0][ADC_W-1:0] phase_current,
    output logic                  cur_valid,
    output logic                  foc_start,
    input  logic                  foc_done,
    output logic                  vel_start,
    input  logic                  vel_done,
    output logic                  busy,
    output logic                  overrun,
    output logic                  adc_fault,
    input  logic                  flag_clr
);

    localparam logic [7:0] VEL_LAST = 8'(VEL_DIV - 1);

    seq_state_e             state_q, state_d;
    logic [7:0]             vel_cnt_q, vel_cnt_d;
    logic [1:0][ADC_W-1:0]  phase_q, phase_d;
    logic                   cur_valid_q, cur_valid_d;
    logic                   foc_start_q, foc_start_d;
    logic                   vel_start_q, vel_start_d;
    logic                   overrun_q, overrun_d;
    logic                   adc_timeout;
    logic                   converting;

    assign converting = (state_q == CONV0) || (state_q == CONV1);

`ifdef SEQ_ADC_TIMEOUT_EN
    logic fault_q, fault_d;

    foc_seq_wdt #(
        .TO (ADC_TO)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (converting),
        .clr     (adc_ack),
        .expired (adc_timeout)
    );

    always_comb begin
        fault_d = fault_q;
        if (flag_clr) begin
            fault_d = 1'b0;
        end
        if (adc_timeout) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign adc_fault = fault_q;
`else
    // Keeps ADC_TO referenced when the watchdog is compiled out.
    logic unused_adc_to;
    assign unused_adc_to = ADC_TO[0];
    assign adc_timeout   = 1'b0;
    assign adc_fault     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        vel_cnt_d   = vel_cnt_q;
        phase_d     = phase_q;
        cur_valid_d = 1'b0;
        foc_start_d = 1'b0;
        vel_start_d = 1'b0;
        overrun_d   = overrun_q;

        if (flag_clr) begin
            overrun_d = 1'b0;
        end
        if (pwm_center && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pwm_center) begin
                    state_d = CONV0;
                end
            end
            CONV0: begin
                if (adc_ack) begin
                    phase_d[0] = adc_data;
                    state_d    = CONV1;
                end else if (adc_timeout) begin
                    state_d = IDLE;
                end
            end
            CONV1: begin
                if (adc_ack) begin
                    phase_d[1]  = adc_data;
                    cur_valid_d = 1'b1;
                    foc_start_d = 1'b1;
                    state_d     = FOC;
                end else if (adc_timeout) begin
                    state_d = IDLE;
                end
            end
            FOC: begin
                if (foc_done) begin
                    if (vel_cnt_q == VEL_LAST) begin
                        vel_cnt_d   = '0;
                        vel_start_d = 1'b1;
                        state_d     = VEL;
                    end else begin
                        vel_cnt_d = vel_cnt_q + 8'd1;
                        state_d   = IDLE;
                    end
                end
            end
            VEL: begin
                if (vel_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vel_cnt_q   <= '0;
            phase_q     <= '0;
            cur_valid_q <= 1'b0;
            foc_start_q <= 1'b0;
            vel_start_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vel_cnt_q   <= vel_cnt_d;
            phase_q     <= phase_d;
            cur_valid_q <= cur_valid_d;
            foc_start_q <= foc_start_d;
            vel_start_q <= vel_start_d;
            overrun_q   <= overrun_d;
        end
    end

    assign adc_req       = converting;
    assign adc_ch        = (state_q == CONV1);
    assign busy          = (state_q != IDLE);
    assign phase_current = phase_q;
    assign cur_valid     = cur_valid_q;
    assign foc_start     = foc_start_q;
    assign vel_start     = vel_start_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_foc_sample_sequencer.sv
// Randomized bench for foc_sample_sequencer against a transaction-level model.
module tb_foc_sample_sequencer;

    localparam int W  = 12;
    localparam int VD = 3;
    localparam int TO = 16;

    logic                clk = 1'b0;
    logic                rst_n, pwm_center, adc_ack, foc_done, vel_done, flag_clr;
    logic [W-1:0]        adc_data;
    logic                adc_req, adc_ch, cur_valid, foc_start, vel_start;
    logic                busy, overrun, adc_fault;
    logic [1:0][W-1:0]   phase_current;

    int        n_cmp = 0;
    int        n_bad = 0;
    int        foc_cnt;
    bit        exp_ovr;
    logic [W-1:0] exp_p0, exp_p1;

    always #5 clk = ~clk;

    foc_sample_sequencer #(
        .ADC_W   (W),
        .VEL_DIV (VD),
        .ADC_TO  (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pwm_center    (pwm_center),
        .adc_req       (adc_req),
        .adc_ch        (adc_ch),
        .adc_ack       (adc_ack),
        .adc_data      (adc_data),
        .phase_current (phase_current),
        .cur_valid     (cur_valid),
        .foc_start     (foc_start),
        .foc_done      (foc_done),
        .vel_start     (vel_start),
        .vel_done      (vel_done),
        .busy          (busy),
        .overrun       (overrun),
        .adc_fault     (adc_fault),
        .flag_clr      (flag_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait n cycles while the sequencer is busy, optionally injecting overrun
    // pulses, flag clears and (when stray_ack) acks that must be ignored.
    task automatic busy_wait(input int n, input bit noisy, input bit stray_ack);
        bit p, c;
        for (int i = 0; i < n; i++) begin
            p = noisy && ($urandom_range(0, 3) == 0);
            c = noisy && ($urandom_range(0, 3) == 0);
            pwm_center = p;
            flag_clr   = c;
            if (stray_ack && noisy && ($urandom_range(0, 2) == 0)) begin
                adc_ack  = 1'b1;
                adc_data = W'($urandom);
            end
            if (p) exp_ovr = 1'b1;
            else if (c) exp_ovr = 1'b0;
            tick();
            pwm_center = 1'b0;
            flag_clr   = 1'b0;
            adc_ack    = 1'b0;
            check_eq("ovr_wait", overrun, exp_ovr);
            check_eq("busy_wait", busy, 1);
        end
    endtask

    // From CONV0 (request already raised) to the return to IDLE.
    task automatic complete_cycle(input logic [W-1:0] d0, input logic [W-1:0] d1, input bit noisy);
        bit vel_exp;
        busy_wait($urandom_range(0, 4), noisy, 1'b0);
        adc_data = d0;
        adc_ack  = 1'b1;
        tick();
        adc_ack  = 1'b0;
        exp_p0   = d0;
        check_eq("conv1_ch", adc_ch, 1);
        check_eq("conv1_req", adc_req, 1);
        check_eq("ph0", phase_current[0], exp_p0);
        busy_wait($urandom_range(0, 4), noisy, 1'b0);
        adc_data = d1;
        adc_ack  = 1'b1;
        tick();
        adc_ack  = 1'b0;
        exp_p1   = d1;
        check_eq("cur_valid", cur_valid, 1);
        check_eq("foc_start", foc_start, 1);
        check_eq("req_drop", adc_req, 0);
        check_eq("phase", phase_current, {exp_p1, exp_p0});
        tick();
        check_eq("cur_valid_pulse", cur_valid, 0);
        check_eq("foc_start_pulse", foc_start, 0);
        check_eq("busy_foc", busy, 1);
        busy_wait($urandom_range(0, 5), noisy, 1'b1);

        foc_cnt++;
        vel_exp  = (foc_cnt % VD) == 0;
        foc_done = 1'b1;
        if (noisy && $urandom_range(0, 1) == 1) begin
            pwm_center = 1'b1;
            exp_ovr    = 1'b1;
        end
        tick();
        foc_done   = 1'b0;
        pwm_center = 1'b0;
        check_eq("vel_start", vel_start, vel_exp);
        check_eq("busy_after_foc", busy, vel_exp);
        check_eq("ovr_foc_done", overrun, exp_ovr);
        if (vel_exp) begin
            busy_wait($urandom_range(0, 4), noisy, 1'b1);
            vel_done = 1'b1;
            tick();
            vel_done = 1'b0;
            check_eq("idle_after_vel", busy, 0);
            check_eq("vel_start_pulse", vel_start, 0);
        end
        check_eq("phase_hold", phase_current, {exp_p1, exp_p0});
    endtask

    task automatic run_cycle(input logic [W-1:0] d0, input logic [W-1:0] d1, input bit noisy);
        pwm_center = 1'b1;
        tick();
        pwm_center = 1'b0;
        check_eq("conv0_req", adc_req, 1);
        check_eq("conv0_ch", adc_ch, 0);
        check_eq("busy_conv", busy, 1);
        complete_cycle(d0, d1, noisy);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"}, adc_req, 0);
        check_eq({tag, "_ch"}, adc_ch, 0);
        check_eq({tag, "_cv"}, cur_valid, 0);
        check_eq({tag, "_fs"}, foc_start, 0);
        check_eq({tag, "_vs"}, vel_start, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ovr"}, overrun, 0);
        check_eq({tag, "_fault"}, adc_fault, 0);
        check_eq({tag, "_phase"}, phase_current, 0);
    endtask

    initial begin
        int  k;
        bit  saw_start;
        bit  held;

        rst_n      = 1'b0;
        pwm_center = 1'b0;
        adc_ack    = 1'b0;
        adc_data   = '0;
        foc_done   = 1'b0;
        vel_done   = 1'b0;
        flag_clr   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        foc_cnt = 0;
        exp_ovr = 1'b0;
        exp_p0  = '0;
        exp_p1  = '0;

        run_cycle(12'h123, 12'hABC, 1'b0);
        check_eq("ovr_clean", overrun, 0);

        for (int i = 0; i < 9; i++) begin
            run_cycle(W'($urandom), W'($urandom), 1'b1);
            tick();
        end

        // Overrun in CONV1 coincident with a clear: the set wins.
        pwm_center = 1'b1;
        tick();
        pwm_center = 1'b0;
        adc_data   = 12'h055;
        adc_ack    = 1'b1;
        tick();
        adc_ack    = 1'b0;
        exp_p0     = 12'h055;
        pwm_center = 1'b1;
        flag_clr   = 1'b1;
        tick();
        pwm_center = 1'b0;
        flag_clr   = 1'b0;
        check_eq("ovr_set_wins", overrun, 1);
        check_eq("conv1_kept", adc_ch, 1);
        adc_data = 12'h0AA;
        adc_ack  = 1'b1;
        tick();
        adc_ack  = 1'b0;
        exp_p1   = 12'h0AA;
        check_eq("foc_after_drop", foc_start, 1);
        tick();
        foc_cnt++;
        foc_done = 1'b1;
        tick();
        foc_done = 1'b0;
        check_eq("vel_dir", vel_start, (foc_cnt % VD) == 0);
        if ((foc_cnt % VD) == 0) begin
            vel_done = 1'b1;
            tick();
            vel_done = 1'b0;
        end
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        exp_ovr  = 1'b0;
        check_eq("ovr_cleared", overrun, 0);
        check_eq("idle_dir", busy, 0);

        // ADC acknowledge never arrives.
        pwm_center = 1'b1;
        tick();
        pwm_center = 1'b0;
        k          = 0;
        saw_start  = 1'b0;
`ifdef SEQ_ADC_TIMEOUT_EN
        while (adc_req === 1'b1 && k < 100) begin
            k++;
            if (foc_start === 1'b1) saw_start = 1'b1;
            tick();
        end
        check_eq("to_len", k, TO);
        check_eq("to_fault", adc_fault, 1);
        check_eq("to_idle", busy, 0);
        check_eq("to_no_start", saw_start, 0);
        check_eq("to_no_valid", cur_valid, 0);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check_eq("fault_cleared", adc_fault, 0);
`else
        held = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (adc_req !== 1'b1 || adc_fault !== 1'b0) held = 1'b0;
            tick();
        end
        check_eq("hold_req", held, 1);
        check_eq("hold_fault", adc_fault, 0);
        complete_cycle(W'($urandom), W'($urandom), 1'b0);
`endif

        // Reset in CONV1, then a late ack that must be ignored.
        pwm_center = 1'b1;
        tick();
        pwm_center = 1'b0;
        adc_data   = 12'h3C3;
        adc_ack    = 1'b1;
        tick();
        adc_ack    = 1'b0;
        check_eq("pre_rst_ch", adc_ch, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("midrst");
        adc_data = 12'h5A5;
        adc_ack  = 1'b1;
        tick();
        adc_ack  = 1'b0;
        check_all_zero("late_ack");
        foc_cnt = 0;
        exp_ovr = 1'b0;

        for (int i = 0; i < 3; i++) begin
            run_cycle(W'($urandom), W'($urandom), 1'b0);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
